// File: rtl/op_mem_ctrl_if.sv
// Bundle of every signal the op-memory controller exchanges with the outside:
// the fetch command, the host load port, the downstream op port and the
// op-memory port. The controller uses the master modport; the environment
// (host, consumer and memory) uses the slave modport.
//
// Handshake rule for both valid/ready ports (ld_* and op_*): a transfer happens
// on a posedge where valid and ready are both high. Once valid is raised the
// offering side keeps valid and its data stable until that transfer. ready may
// depend combinationally on the other side's inputs but never on valid.
`timescale 1ns/1ps
interface op_mem_ctrl_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) ();
  // fetch command
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] num_ops;
  // host load port
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;
  // downstream op port
  logic              op_valid;
  logic [DATA_W-1:0] op_data;
  logic              op_ready;
  // status
  logic              busy;
  logic              done;
  // op-memory port
  logic [ADDR_W-1:0] opCount;
  logic              opRW;
  logic              opEN;
  logic [DATA_W-1:0] opWriteBus;
  logic [DATA_W-1:0] opBus;

  modport master (
    input  start, base_addr, num_ops, ld_valid, ld_addr, ld_data, op_ready, opBus,
    output ld_ready, op_valid, op_data, busy, done, opCount, opRW, opEN, opWriteBus
  );

  modport slave (
    output start, base_addr, num_ops, ld_valid, ld_addr, ld_data, op_ready, opBus,
    input  ld_ready, op_valid, op_data, busy, done, opCount, opRW, opEN, opWriteBus
  );
endinterface

// File: rtl/op_mem_ctrl.sv
// Op-memory controller: sole master of the op-memory port. Loads single words
// from the host port and fetches a wrapping range of slots to a consumer.
// Memory contract: the memory acts on the posedge where it sees opEN=1; read
// data is captured one posedge later (the RD_WAIT cycle covers that gap).
`timescale 1ns/1ps
module op_mem_ctrl #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  op_mem_ctrl_if.master bus,
  output logic [2:0]   state_dbg_o
);

  // DEPTH must be representable in ADDR_W bits (num_ops clamps to it).
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    RD_REQ  = 3'd2,
    RD_WAIT = 3'd3,
    HOLD    = 3'd4
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] rem_q;
  logic [ADDR_W-1:0] op_count_q;
  logic              op_rw_q;
  logic              op_en_q;
  logic [DATA_W-1:0] op_wbus_q;
  logic              op_valid_q;
  logic [DATA_W-1:0] op_data_q;
  logic              done_q;

  logic [ADDR_W-1:0] num_eff;
  logic [ADDR_W-1:0] base_wrap;
  logic [ADDR_W-1:0] ld_wrap;
  logic [ADDR_W-1:0] addr_d;

  // Command decoding: clamp the op count, wrap addresses into the slot range,
  // and compute the wrapped successor of the current fetch address.
  always_comb begin
    num_eff   = (bus.num_ops > DEPTH_A) ? DEPTH_A : bus.num_ops;
    base_wrap = bus.base_addr % DEPTH_A;
    ld_wrap   = bus.ld_addr % DEPTH_A;
    addr_d    = (addr_q == LAST_A) ? '0 : addr_q + ADDR_W'(1);
  end

  // Main FSM: all memory-side and op-port outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      op_count_q <= '0;
      op_rw_q    <= 1'b1;
      op_en_q    <= 1'b0;
      op_wbus_q  <= '0;
      op_valid_q <= 1'b0;
      op_data_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (num_eff == '0) begin
              // empty fetch: acknowledge without touching the memory
              done_q <= 1'b1;
            end else begin
              addr_q     <= base_wrap;
              rem_q      <= num_eff;
              op_count_q <= base_wrap;
              op_en_q    <= 1'b1;
              op_rw_q    <= 1'b1;
              state_q    <= RD_REQ;
            end
          end else if (bus.ld_valid) begin
            // ld_ready is high here because start is low
            op_count_q <= ld_wrap;
            op_wbus_q  <= bus.ld_data;
            op_rw_q    <= 1'b0;
            op_en_q    <= 1'b1;
            state_q    <= WR_REQ;
          end
        end
        WR_REQ: begin
          op_en_q <= 1'b0;
          op_rw_q <= 1'b1;
          state_q <= IDLE;
        end
        RD_REQ: begin
          op_en_q <= 1'b0;
          state_q <= RD_WAIT;
        end
        RD_WAIT: begin
          op_data_q  <= bus.opBus;
          op_valid_q <= 1'b1;
          state_q    <= HOLD;
        end
        HOLD: begin
          if (bus.op_ready) begin
            op_valid_q <= 1'b0;
            rem_q      <= rem_q - ADDR_W'(1);
            addr_q     <= addr_d;
            if (rem_q == ADDR_W'(1)) begin
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              op_count_q <= addr_d;
              op_en_q    <= 1'b1;
              op_rw_q    <= 1'b1;
              state_q    <= RD_REQ;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ld_ready   = (state_q == IDLE) && !bus.start;
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = done_q;
  assign bus.op_valid   = op_valid_q;
  assign bus.op_data    = op_data_q;
  assign bus.opCount    = op_count_q;
  assign bus.opRW       = op_rw_q;
  assign bus.opEN       = op_en_q;
  assign bus.opWriteBus = op_wbus_q;
  assign state_dbg_o    = state_q;

endmodule

// File: tb/tb_op_mem_ctrl.sv
// Bench for op_mem_ctrl: memory model on the op port, host/consumer drivers,
// table of fetch vectors, hand sequences for backpressure and reset, and
// randomized load/fetch rounds checked against a slot-array reference.
`timescale 1ns/1ps
module tb_op_mem_ctrl;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  op_mem_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  logic [2:0] state_dbg;

  op_mem_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .state_dbg_o (state_dbg)
  );

  // ---------------- op-memory model ----------------
  logic [DATA_W-1:0] mem [DEPTH];
  logic              prev_en;
  int                b2b_err = 0;
  int                range_err = 0;
  int                wr_cnt = 0;
  logic [ADDR_W-1:0] rd_log[$];

  // memory acts on the edge where it samples opEN; read data valid after it
  always @(posedge clk) begin
    if (bus.opEN) begin
      if (prev_en === 1'b1) b2b_err++;
      if (bus.opCount >= ADDR_W'(DEPTH)) range_err++;
      if (!bus.opRW) begin
        mem[bus.opCount[2:0]] <= bus.opWriteBus;
        wr_cnt++;
      end else begin
        bus.opBus <= mem[bus.opCount[2:0]];
        rd_log.push_back(bus.opCount);
      end
    end
    prev_en <= bus.opEN;
  end

  // ---------------- scoreboard ----------------
  int                n_chk = 0;
  int                n_err = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] ref_mem [DEPTH];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    int n;
    int slot;
    slot = int'(a) % DEPTH;
    bus.ld_valid = 1'b1;
    bus.ld_addr  = a;
    bus.ld_data  = d;
    #1;
    n = 0;
    while (!bus.ld_ready && n < 20) begin
      tick();
      n++;
    end
    chk("load_ready_timeout", 32'(bus.ld_ready), 32'd1);
    tick();
    bus.ld_valid = 1'b0;
    tick();
    ref_mem[slot] = d;
    chk("load_slot_data", mem[slot], d);
  endtask

  // Issue one fetch and consume it; extraneous inputs are randomized while busy.
  task automatic run_fetch(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] num,
                           input int ready_pct, output int n_got,
                           output logic [DATA_W-1:0] first_w, output logic [DATA_W-1:0] last_w);
    int eff, cyc, last_v, rd0, wr0, dones;
    logic [ADDR_W-1:0] exp_addr[$];
    eff = (int'(num) > DEPTH) ? DEPTH : int'(num);
    exp_q.delete();
    for (int k = 0; k < eff; k++) begin
      exp_q.push_back(ref_mem[(int'(base) + k) % DEPTH]);
      exp_addr.push_back(ADDR_W'((int'(base) + k) % DEPTH));
    end
    rd0 = rd_log.size();
    wr0 = wr_cnt;
    n_got = 0; first_w = '0; last_w = '0; last_v = -1; dones = 0;
    bus.start     = 1'b1;
    bus.base_addr = base;
    bus.num_ops   = num;
    bus.ld_valid  = 1'b0;
    tick();
    cyc = 0;
    while (cyc < 300) begin
      if (bus.done) begin
        dones++;
        break;
      end
      if (bus.busy) begin
        bus.start     = 1'($urandom_range(0, 1));
        bus.ld_valid  = 1'($urandom_range(0, 1));
        bus.ld_addr   = ADDR_W'($urandom);
        bus.ld_data   = $urandom;
        bus.base_addr = ADDR_W'($urandom);
        bus.num_ops   = ADDR_W'($urandom);
      end else begin
        bus.start    = 1'b0;
        bus.ld_valid = 1'b0;
      end
      bus.op_ready = ($urandom_range(1, 100) <= ready_pct);
      if (bus.op_valid) begin
        if (exp_q.size() == 0) begin
          chk("op_unexpected", 32'(bus.op_valid), 32'd0);
        end else begin
          chk("op_data", bus.op_data, exp_q[0]);
          if (ready_pct == 100) begin
            if (last_v >= 0) chk("op_spacing", 32'(cyc - last_v), 32'd3);
            last_v = cyc;
          end
          if (!bus.op_ready) chk("stall_open_low", 32'(bus.opEN), 32'd0);
          if (bus.op_ready) begin
            if (n_got == 0) first_w = bus.op_data;
            last_w = bus.op_data;
            n_got++;
            void'(exp_q.pop_front());
          end
        end
      end
      tick();
      cyc++;
    end
    bus.start    = 1'b0;
    bus.ld_valid = 1'b0;
    chk("fetch_done_seen", 32'(dones), 32'd1);
    chk("busy_low_at_done", 32'(bus.busy), 32'd0);
    chk("all_ops_before_done", 32'(exp_q.size()), 32'd0);
    chk("read_count", 32'(rd_log.size() - rd0), 32'(eff));
    for (int k = 0; k < eff && (rd0 + k) < rd_log.size(); k++)
      chk("read_addr", 32'(rd_log[rd0 + k]), 32'(exp_addr[k]));
    chk("no_write_in_fetch", 32'(wr_cnt - wr0), 32'd0);
    tick();
    chk("done_one_cycle", 32'(bus.done), 32'd0);
    chk("busy_low_after", 32'(bus.busy), 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] num;
    int                exp_n;
    logic [DATA_W-1:0] exp_first;
    logic [DATA_W-1:0] exp_last;
  } fetch_vec_t;

  fetch_vec_t tbl [7];

  task automatic wait_valid(input string nm);
    int n;
    n = 0;
    while (!bus.op_valid && n < 20) begin
      tick();
      n++;
    end
    chk(nm, 32'(bus.op_valid), 32'd1);
  endtask

  // ---------------- main test ----------------
  initial begin
    int got;
    logic [DATA_W-1:0] fw, lw;

    tbl[0] = '{4'd0,  4'd8,  8, 32'h100, 32'h107};
    tbl[1] = '{4'd6,  4'd4,  4, 32'h106, 32'h101};
    tbl[2] = '{4'd0,  4'd0,  0, 32'h0,   32'h0};
    tbl[3] = '{4'd0,  4'd12, 8, 32'h100, 32'h107};
    tbl[4] = '{4'd13, 4'd3,  3, 32'h105, 32'h107};
    tbl[5] = '{4'd7,  4'd1,  1, 32'h107, 32'h107};
    tbl[6] = '{4'd3,  4'd15, 8, 32'h103, 32'h102};

    bus.start = 1'b0; bus.base_addr = '0; bus.num_ops = '0;
    bus.ld_valid = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;
    bus.op_ready = 1'b0;
    rst = 1'b1;
    repeat (3) tick();

    // reset values
    chk("rst_opEN", 32'(bus.opEN), 32'd0);
    chk("rst_opRW", 32'(bus.opRW), 32'd1);
    chk("rst_opCount", 32'(bus.opCount), 32'd0);
    chk("rst_opWriteBus", bus.opWriteBus, 32'd0);
    chk("rst_op_valid", 32'(bus.op_valid), 32'd0);
    chk("rst_op_data", bus.op_data, 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    tick();

    // single write, cycle by cycle
    bus.ld_valid = 1'b1; bus.ld_addr = 4'd3; bus.ld_data = 32'hDEADBEEF;
    #1;
    chk("wr_ld_ready", 32'(bus.ld_ready), 32'd1);
    tick();
    bus.ld_valid = 1'b0;
    chk("wr_opEN", 32'(bus.opEN), 32'd1);
    chk("wr_opRW", 32'(bus.opRW), 32'd0);
    chk("wr_opCount", 32'(bus.opCount), 32'd3);
    chk("wr_opWriteBus", bus.opWriteBus, 32'hDEADBEEF);
    chk("wr_ld_ready_low", 32'(bus.ld_ready), 32'd0);
    tick();
    chk("wr_end_opEN", 32'(bus.opEN), 32'd0);
    chk("wr_end_opRW", 32'(bus.opRW), 32'd1);
    chk("wr_end_ld_ready", 32'(bus.ld_ready), 32'd1);
    chk("wr_mem_slot3", mem[3], 32'hDEADBEEF);
    ref_mem[3] = 32'hDEADBEEF;

    // fill all slots, then apply the fetch table
    for (int i = 0; i < DEPTH; i++) do_load(ADDR_W'(i), 32'h100 + 32'(i));
    for (int v = 0; v < 7; v++) begin
      run_fetch(tbl[v].base, tbl[v].num, 100, got, fw, lw);
      chk("tbl_n_ops", 32'(got), 32'(tbl[v].exp_n));
      if (tbl[v].exp_n > 0) begin
        chk("tbl_first_word", fw, tbl[v].exp_first);
        chk("tbl_last_word", lw, tbl[v].exp_last);
      end
    end

    // backpressure on the first op
    bus.start = 1'b1; bus.base_addr = 4'd2; bus.num_ops = 4'd2;
    tick();
    bus.start = 1'b0;
    bus.op_ready = 1'b0;
    wait_valid("bp_first_valid");
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid_held", 32'(bus.op_valid), 32'd1);
      chk("bp_data_held", bus.op_data, ref_mem[2]);
      chk("bp_open_low", 32'(bus.opEN), 32'd0);
      chk("bp_count_held", 32'(bus.opCount), 32'd2);
      tick();
    end
    bus.op_ready = 1'b1;
    tick();
    chk("bp_valid_drop", 32'(bus.op_valid), 32'd0);
    chk("bp_next_opEN", 32'(bus.opEN), 32'd1);
    chk("bp_next_count", 32'(bus.opCount), 32'd3);
    wait_valid("bp_second_valid");
    chk("bp_second_data", bus.op_data, ref_mem[3]);
    tick();
    chk("bp_done", 32'(bus.done), 32'd1);
    bus.op_ready = 1'b0;
    tick();
    chk("bp_done_once", 32'(bus.done), 32'd0);

    // start beats a simultaneous load; reset in HOLD of the second op
    bus.start = 1'b1; bus.base_addr = 4'd0; bus.num_ops = 4'd3;
    bus.ld_valid = 1'b1; bus.ld_addr = 4'd2; bus.ld_data = 32'hBAD0BAD0;
    #1;
    chk("prio_ld_ready_low", 32'(bus.ld_ready), 32'd0);
    tick();
    bus.start = 1'b0; bus.ld_valid = 1'b0;
    chk("prio_read_en", 32'(bus.opEN), 32'd1);
    chk("prio_read_rw", 32'(bus.opRW), 32'd1);
    chk("prio_busy", 32'(bus.busy), 32'd1);
    chk("prio_count", 32'(bus.opCount), 32'd0);
    bus.op_ready = 1'b1;
    wait_valid("rst_seq_op0_valid");
    chk("rst_seq_op0_data", bus.op_data, ref_mem[0]);
    tick();
    bus.op_ready = 1'b0;
    wait_valid("rst_seq_op1_valid");
    chk("rst_seq_op1_data", bus.op_data, ref_mem[1]);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_opEN", 32'(bus.opEN), 32'd0);
    chk("mid_rst_opRW", 32'(bus.opRW), 32'd1);
    chk("mid_rst_opCount", 32'(bus.opCount), 32'd0);
    chk("mid_rst_opWriteBus", bus.opWriteBus, 32'd0);
    chk("mid_rst_op_valid", 32'(bus.op_valid), 32'd0);
    chk("mid_rst_op_data", bus.op_data, 32'd0);
    chk("mid_rst_done", 32'(bus.done), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_state_dbg", 32'(state_dbg), 32'd0);
    tick();
    chk("post_rst_done", 32'(bus.done), 32'd0);
    chk("post_rst_opEN", 32'(bus.opEN), 32'd0);
    chk("lost_load_not_written", mem[2], ref_mem[2]);

    // randomized rounds against the slot-array reference
    for (int r = 0; r < 12; r++) begin
      int nl;
      nl = $urandom_range(0, 3);
      for (int j = 0; j < nl; j++) do_load(ADDR_W'($urandom), $urandom);
      run_fetch(ADDR_W'($urandom), ADDR_W'($urandom), 60, got, fw, lw);
    end

    chk("no_back_to_back_en", 32'(b2b_err), 32'd0);
    chk("opCount_in_range", 32'(range_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // global time bound
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

endmodule
